// File: rtl/pwm_axil_regs_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_axil_regs_slave_if
// Description : AXI4-Lite bus bundle between the bench/SoC master and the
//               PWM register slave.
//               Write address : AWADDR, AWPROT, AWVALID / AWREADY
//               Write data    : WDATA, WSTRB, WVALID / WREADY
//               Write response: BRESP, BVALID / BREADY
//               Read address  : ARADDR, ARPROT, ARVALID / ARREADY
//               Read data     : RDATA, RRESP, RVALID / RREADY
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_axil_regs_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/pwm_axil_regs_slave.sv
`default_nettype none
// ============================================================================
// Module      : pwm_axil_regs_slave
// Description : AXI4-Lite slave with four 32-bit registers (CTRL, PERIOD,
//               DUTY, PRESCALE) and the PWM generator they control.
// Ports       : ACLK        in   clock
//               ARESETN     in   asynchronous active-low reset
//               S_AXI       if   AXI4-Lite slave modport
//               pwm_out     out  PWM waveform (registered)
//               period_tick out  one-cycle pulse at each PWM period wrap
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_axil_regs_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_W              = 16
) (
  input  wire                          ACLK,
  input  wire                          ARESETN,
  pwm_axil_regs_slave_if.slave         S_AXI,
  output logic                         pwm_out,
  output logic                         period_tick
);

  localparam int NREG   = 4;
  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  // --------------------------------------------------------------------------
  // Bus handshake state
  // --------------------------------------------------------------------------
  logic awready_q, awready_d;
  logic bvalid_q,  bvalid_d;
  logic arready_q, arready_d;
  logic rvalid_q,  rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NREG];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [NREG];

  logic       w_wr_en;
  logic       w_rd_en;
  logic [1:0] w_wsel;
  logic [1:0] w_rsel;

  assign w_wsel = S_AXI.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rsel = S_AXI.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // The ready pulse raised last cycle completes the transfer now; the master
  // keeps VALID up until it sees READY, so VALID is still asserted here.
  assign w_wr_en = awready_q & S_AXI.AWVALID & S_AXI.WVALID;
  assign w_rd_en = arready_q & S_AXI.ARVALID;

  always_comb begin
    // AW and W are accepted together only; the ~awready_q term makes the
    // ready a single-cycle pulse.
    awready_d = S_AXI.AWVALID & S_AXI.WVALID & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q;
    if (w_wr_en)
      bvalid_d = 1'b1;
    else if (bvalid_q && S_AXI.BREADY)
      bvalid_d = 1'b0;

    arready_d = S_AXI.ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (w_rd_en) begin
      rvalid_d = 1'b1;
      // regs_q is the pre-write value, so a concurrent write to the same
      // register is not visible to this read.
      rdata_d  = regs_q[w_rsel];
    end else if (rvalid_q && S_AXI.RREADY) begin
      rvalid_d = 1'b0;
    end

    for (int r = 0; r < NREG; r++)
      regs_d[r] = regs_q[r];
    if (w_wr_en) begin
      for (int b = 0; b < NBYTES; b++)
        if (S_AXI.WSTRB[b])
          regs_d[w_wsel][8*b +: 8] = S_AXI.WDATA[8*b +: 8];
    end
  end

  assign S_AXI.AWREADY = awready_q;
  assign S_AXI.WREADY  = awready_q;
  assign S_AXI.BVALID  = bvalid_q;
  assign S_AXI.BRESP   = 2'b00;
  assign S_AXI.ARREADY = arready_q;
  assign S_AXI.RVALID  = rvalid_q;
  assign S_AXI.RDATA   = rdata_q;
  assign S_AXI.RRESP   = 2'b00;

  // --------------------------------------------------------------------------
  // PWM core
  // --------------------------------------------------------------------------
  logic             w_enable;
  logic             w_pol;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_duty;
  logic [CNT_W-1:0] w_prescale;

  assign w_enable   = regs_q[0][0];
  assign w_pol      = regs_q[0][1];
  assign w_period   = regs_q[1][CNT_W-1:0];
  assign w_duty     = regs_q[2][CNT_W-1:0];
  assign w_prescale = regs_q[3][CNT_W-1:0];

  logic             en_prev_q, en_prev_d;
  logic [CNT_W-1:0] presc_q,   presc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] per_sh_q,  per_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic             pwm_q,     pwm_d;
  logic             ptick_q,   ptick_d;

  always_comb begin
    en_prev_d = w_enable;
    presc_d   = '0;
    cnt_d     = '0;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    pwm_d     = w_pol;
    ptick_d   = 1'b0;
    if (w_enable) begin
      if (!en_prev_q) begin
        // First enabled cycle: load shadows; counting starts next cycle.
        per_sh_d  = w_period;
        duty_sh_d = w_duty;
      end else begin
        pwm_d   = (cnt_q < duty_sh_q) ^ w_pol;
        presc_d = presc_q + CNT_W'(1);
        cnt_d   = cnt_q;
        // >= rather than == so lowering PRESCALE below the running count
        // wraps immediately instead of rolling through the full range.
        if (presc_q >= w_prescale) begin
          presc_d = '0;
          if (cnt_q >= per_sh_q) begin
            cnt_d     = '0;
            ptick_d   = 1'b1;
            per_sh_d  = w_period;
            duty_sh_d = w_duty;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = ptick_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int r = 0; r < NREG; r++)
        regs_q[r] <= '0;
      en_prev_q <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
      ptick_q   <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      for (int r = 0; r < NREG; r++)
        regs_q[r] <= regs_d[r];
      en_prev_q <= en_prev_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
      ptick_q   <= ptick_d;
    end
  end

  // Protection bits and the byte offset within a word carry no meaning here.
  logic w_unused_ok;
  assign w_unused_ok = ^{S_AXI.AWPROT, S_AXI.ARPROT,
                         S_AXI.AWADDR[1:0], S_AXI.ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_pwm_axil_regs_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_axil_regs_slave
// Description : Directed self-checking bench for pwm_axil_regs_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_axil_regs_slave;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic pwm_out;
  logic period_tick;

  int checks   = 0;
  int failures = 0;

  pwm_axil_regs_slave_if bus ();

  pwm_axil_regs_slave dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .S_AXI       (bus),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic hs;
    hs = 1'b0;
    bus.AWADDR  = addr;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    bus.BREADY  = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge ACLK);
      if (bus.AWREADY && bus.WREADY) hs = 1'b1;
    end
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    check("wr_accept", {31'd0, hs}, 32'd1);
    check("wr_bvalid", {31'd0, bus.BVALID}, 32'd1);
    check("wr_bresp", {30'd0, bus.BRESP}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic hs;
    hs = 1'b0;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge ACLK);
      if (bus.ARREADY) hs = 1'b1;
    end
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    check("rd_accept", {31'd0, hs}, 32'd1);
    check("rd_rvalid", {31'd0, bus.RVALID}, 32'd1);
    check("rd_rresp", {30'd0, bus.RRESP}, 32'd0);
    data = bus.RDATA;
  endtask

  task automatic wait_tick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge ACLK);
      if (period_tick) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic count_win(input int n, output int highs, output int ticks);
    highs = 0;
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      if (pwm_out) highs++;
      if (period_tick) ticks++;
    end
  endtask

  logic [31:0] rd;
  int          hi, tk;
  logic        samp [20];
  logic        hs2;

  initial begin
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA  = '0; bus.WSTRB  = '0; bus.WVALID  = 1'b0;
    bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, bus.BVALID},  32'd0);
    check("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
    check("rst_rvalid",  {31'd0, bus.RVALID},  32'd0);
    check("rst_rdata",   bus.RDATA,            32'd0);
    check("rst_pwm",     {31'd0, pwm_out},     32'd0);
    check("rst_ptick",   {31'd0, period_tick}, 32'd0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // 1: basic write / readback
    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'hC, 32'd4, 4'hF);
    axi_read(4'h0, rd); check("rb_ctrl",  rd, 32'd1);
    axi_read(4'h4, rd); check("rb_per",   rd, 32'd2);
    axi_read(4'h8, rd); check("rb_duty",  rd, 32'd3);
    axi_read(4'hD, rd); check("rb_presc_unaligned", rd, 32'd4);

    // 2: byte strobe, plus full 32-bit storage
    axi_write(4'h0, 32'd0, 4'hF);
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
    axi_read(4'h4, rd); check("strb_lane1", rd, 32'h0000CC00);
    axi_write(4'h8, 32'hDEADBEEF, 4'hF);
    axi_read(4'h8, rd); check("full_word", rd, 32'hDEADBEEF);

    // 5: BVALID back-pressure blocks a second write
    bus.BREADY  = 1'b0;
    bus.AWADDR  = 4'h4; bus.WDATA = 32'h11; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    hs2 = 1'b0;
    for (int i = 0; i < 20 && !hs2; i++) begin
      @(negedge ACLK);
      if (bus.AWREADY) hs2 = 1'b1;
    end
    @(negedge ACLK);
    check("bp_first_accept", {31'd0, hs2}, 32'd1);
    bus.WDATA = 32'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bp_bvalid_hold", {31'd0, bus.BVALID}, 32'd1);
      check("bp_awready_low", {31'd0, bus.AWREADY}, 32'd0);
      check("bp_wready_low",  {31'd0, bus.WREADY},  32'd0);
    end
    bus.BREADY = 1'b1;
    hs2 = 1'b0;
    for (int i = 0; i < 20 && !hs2; i++) begin
      @(negedge ACLK);
      if (bus.AWREADY) hs2 = 1'b1;
    end
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("bp_second_accept", {31'd0, hs2}, 32'd1);
    @(negedge ACLK);
    axi_read(4'h4, rd); check("bp_second_data", rd, 32'h22);

    // 3: PWM period 10, duty 3, no prescale
    axi_write(4'hC, 32'd0, 4'hF);
    axi_write(4'h4, 32'd9, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    wait_tick("pwm_tick_seen");
    count_win(20, hi, tk);
    check("pwm_high_20", hi, 32'd6);
    check("pwm_ticks_20", tk, 32'd2);
    axi_write(4'h0, 32'd3, 4'hF);
    repeat (3) @(negedge ACLK);
    count_win(10, hi, tk);
    check("pwm_inv_high", hi, 32'd7);
    axi_write(4'h0, 32'd1, 4'hF);
    repeat (3) @(negedge ACLK);

    // 4: mid-period duty change lands on the next period
    wait_tick("mid_tick_seen");
    fork
      begin
        @(negedge ACLK);
        axi_write(4'h8, 32'd7, 4'hF);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge ACLK);
          samp[i] = pwm_out;
        end
      end
    join
    hi = 0;
    for (int i = 0; i < 10; i++) if (samp[i]) hi++;
    check("mid_cur_period", hi, 32'd3);
    hi = 0;
    for (int i = 10; i < 20; i++) if (samp[i]) hi++;
    check("mid_next_period", hi, 32'd7);

    // PERIOD=0 with DUTY>PERIOD: tick every cycle, output constant high
    axi_write(4'h4, 32'd0, 4'hF);
    repeat (15) @(negedge ACLK);
    count_win(10, hi, tk);
    check("p0_ticks", tk, 32'd10);
    check("p0_duty_gt_high", hi, 32'd10);
    // Prescale by 2
    axi_write(4'hC, 32'd1, 4'hF);
    repeat (4) @(negedge ACLK);
    count_win(10, hi, tk);
    check("presc1_ticks", tk, 32'd5);

    // 6: DUTY=0 inverted gives constant 1; then reset mid-read
    axi_write(4'hC, 32'd0, 4'hF);
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'h0, 32'd3, 4'hF);
    repeat (6) @(negedge ACLK);
    count_win(10, hi, tk);
    check("duty0_inv_high", hi, 32'd10);
    bus.RREADY  = 1'b0;
    bus.ARADDR  = 4'h0;
    bus.ARVALID = 1'b1;
    hs2 = 1'b0;
    for (int i = 0; i < 20 && !hs2; i++) begin
      @(negedge ACLK);
      if (bus.ARREADY) hs2 = 1'b1;
    end
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    check("hold_rd_accept", {31'd0, hs2}, 32'd1);
    repeat (2) @(negedge ACLK);
    check("hold_rvalid", {31'd0, bus.RVALID}, 32'd1);
    check("hold_rdata",  bus.RDATA, 32'd3);
    #2 ARESETN = 1'b0;
    #1;
    check("arst_rvalid", {31'd0, bus.RVALID}, 32'd0);
    check("arst_rdata",  bus.RDATA,           32'd0);
    check("arst_pwm",    {31'd0, pwm_out},    32'd0);
    check("arst_ptick",  {31'd0, period_tick}, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN    = 1'b1;
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    axi_read(4'h0, rd); check("post_rst_ctrl",  rd, 32'd0);
    axi_read(4'h4, rd); check("post_rst_per",   rd, 32'd0);
    axi_read(4'h8, rd); check("post_rst_duty",  rd, 32'd0);
    axi_read(4'hC, rd); check("post_rst_presc", rd, 32'd0);
    check("post_rst_pwm", {31'd0, pwm_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
